// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall encodings, exception causes, FSM states.
package pipeline_ctrl_pkg;

    localparam int unsigned STALL_W = 6;
    localparam int unsigned DATA_W  = 32;

    // stall[0]=PC ... stall[5]=WB; a request holds its own stage and everything upstream
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
    localparam logic [STALL_W-1:0] STALL_ALL  = 6'b111111;

    localparam logic [DATA_W-1:0] EXC_NONE         = 32'h0000_0000;
    localparam logic [DATA_W-1:0] EXC_INTERRUPT    = 32'h0000_0001;
    localparam logic [DATA_W-1:0] EXC_SYSCALL      = 32'h0000_0008;
    localparam logic [DATA_W-1:0] EXC_INST_INVALID = 32'h0000_000a;
    localparam logic [DATA_W-1:0] EXC_OVERFLOW     = 32'h0000_000c;
    localparam logic [DATA_W-1:0] EXC_TRAP         = 32'h0000_000d;
    localparam logic [DATA_W-1:0] EXC_ERET         = 32'h0000_000e;

    localparam logic [DATA_W-1:0] HANDLER_ADDR_DEFAULT = 32'h0000_0020;

    // ST_FREEZE is the exception-detect cycle, folded into ST_RUN's exception branch
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FREEZE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FLUSH  = 2'd3
    } state_e;

endpackage

// File: rtl/pipeline_ctrl_stall_arbiter.sv
// Combinational priority encoder: deepest requesting stage wins (MEM > EX > ID > IF).
module stall_arbiter
    import pipeline_ctrl_pkg::*;
(
    input  logic               stallreq_if,
    input  logic               stallreq_id,
    input  logic               stallreq_ex,
    input  logic               stallreq_mem,
    output logic [STALL_W-1:0] stall_c
);

    always_comb begin
        stall_c = STALL_NONE;
        if (stallreq_mem)     stall_c = STALL_MEM;
        else if (stallreq_ex) stall_c = STALL_EX;
        else if (stallreq_id) stall_c = STALL_ID;
        else if (stallreq_if) stall_c = STALL_IF;
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: stall arbitration, exception freeze/drain/flush sequencing,
// stall-cycle performance counter and sticky stall watchdog.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [DATA_W-1:0] HANDLER_ADDR = HANDLER_ADDR_DEFAULT,
    parameter int unsigned       WDOG_LIMIT   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_if,
    input  logic               stallreq_id,
    input  logic               stallreq_ex,
    input  logic               stallreq_mem,
    input  logic [DATA_W-1:0]  excepttype_i,
    input  logic [DATA_W-1:0]  cp0_epc_i,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [DATA_W-1:0]  new_pc,
    output logic [DATA_W-1:0]  stall_cycles,
    output logic               wdog_timeout
);

    localparam int unsigned WDOG_W = $clog2(WDOG_LIMIT + 1);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [DATA_W-1:0]   r_target;
    logic [DATA_W-1:0]   w_target_nxt;
    logic                r_flush;
    logic [DATA_W-1:0]   r_new_pc;
    logic [DATA_W-1:0]   r_stall_cycles;
    logic [WDOG_W-1:0]   r_wdog_cnt;
    logic                r_wdog_timeout;
    logic [STALL_W-1:0]  w_arb_stall;
    logic [STALL_W-1:0]  w_stall;
    logic                w_stalled;

    stall_arbiter u_stall_arbiter (
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .stall_c      (w_arb_stall)
    );

    // Next-state, redirect target and combinational stall vector
    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_stall      = STALL_NONE;
        case (r_state)
            ST_RUN: begin
                if (excepttype_i != EXC_NONE) begin
                    w_stall      = STALL_ALL;
                    w_target_nxt = (excepttype_i == EXC_ERET) ? cp0_epc_i : HANDLER_ADDR;
                    w_state_nxt  = stallreq_mem ? ST_DRAIN : ST_FLUSH;
                end else begin
                    w_stall = w_arb_stall;
                end
            end
            ST_DRAIN: begin
                w_stall = STALL_ALL;
                if (!stallreq_mem) w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // State register; flush/new_pc are registered Moore outputs of ST_FLUSH
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_target <= '0;
            r_flush  <= 1'b0;
            r_new_pc <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_target <= w_target_nxt;
            r_flush  <= (w_state_nxt == ST_FLUSH);
            r_new_pc <= (w_state_nxt == ST_FLUSH) ? w_target_nxt : '0;
        end
    end

    assign w_stalled = (w_stall != STALL_NONE);

    // Stall-cycle counter (free-running, wraps) and watchdog run-length counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_wdog_cnt     <= '0;
            r_wdog_timeout <= 1'b0;
        end else begin
            if (w_stalled) r_stall_cycles <= r_stall_cycles + DATA_W'(1);
            if (!w_stalled || r_state == ST_FLUSH) begin
                r_wdog_cnt <= '0;
            end else begin
                if (r_wdog_cnt != WDOG_W'(WDOG_LIMIT)) r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
                if (r_wdog_cnt == WDOG_W'(WDOG_LIMIT - 1)) r_wdog_timeout <= 1'b1;
            end
        end
    end

    assign stall        = w_stall;
    assign flush        = r_flush;
    assign new_pc       = r_new_pc;
    assign stall_cycles = r_stall_cycles;
    assign wdog_timeout = r_wdog_timeout;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed cases plus random traffic against a behavioural model.
module tb_pipeline_ctrl;

    localparam int unsigned LIMIT = 4;
    localparam logic [31:0] HADDR = 32'h0000_0020;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic [31:0] excepttype_i, cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc, stall_cycles;
    logic        wdog_timeout;

    always #5 clk = ~clk;

    pipeline_ctrl #(.HANDLER_ADDR(HADDR), .WDOG_LIMIT(LIMIT)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .excepttype_i (excepttype_i),
        .cp0_epc_i    (cp0_epc_i),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_cycles (stall_cycles),
        .wdog_timeout (wdog_timeout)
    );

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] new_pc;
        logic [31:0] cyc;
        logic        wd;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_mis = 0;

    // Behavioural model: pending flush, draining flag, target, counters
    bit          m_flush = 0;
    bit          m_drain = 0;
    logic [31:0] m_target = '0;
    logic [31:0] m_cnt = '0;
    int          m_run = 0;
    bit          m_wd = 0;

    function automatic logic [5:0] prio_stall(bit f, bit i, bit e, bit m);
        int held;
        held = m ? 5 : e ? 4 : i ? 3 : f ? 2 : 0;
        return 6'((1 << held) - 1);
    endfunction

    task automatic step(input bit r, input bit f, input bit i, input bit e, input bit m,
                        input logic [31:0] exc, input logic [31:0] epc, input string tag,
                        input bit check);
        exp_t       x;
        logic [5:0] s;
        @(negedge clk);
        rst = r; stallreq_if = f; stallreq_id = i; stallreq_ex = e; stallreq_mem = m;
        excepttype_i = exc; cp0_epc_i = epc;
        if (m_flush)                  s = 6'd0;
        else if (m_drain || exc != 0) s = 6'h3f;
        else                          s = prio_stall(f, i, e, m);
        x.stall = s; x.flush = m_flush; x.new_pc = m_target; x.cyc = m_cnt; x.wd = m_wd; x.tag = tag;
        if (check) q.push_back(x);
        if (r) begin
            m_flush = 0; m_drain = 0; m_target = '0; m_cnt = '0; m_run = 0; m_wd = 0;
        end else begin
            if (s != 0) begin
                m_cnt = m_cnt + 32'd1;
                m_run++;
                if (m_run >= LIMIT) m_wd = 1;
            end else begin
                m_run = 0;
            end
            if (m_flush) m_flush = 0;
            else if (m_drain) begin
                if (!m) begin m_drain = 0; m_flush = 1; end
            end else if (exc != 0) begin
                m_target = (exc == 32'he) ? epc : HADDR;
                if (m) m_drain = 1; else m_flush = 1;
            end
        end
    endtask

    task automatic idle(input string tag);
        step(0, 0, 0, 0, 0, 32'd0, 32'd0, tag, 1);
    endtask

    task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s %s: got %h expected %h", tag, name, act, exp);
        end
    endtask

    // Monitor: compare just before each rising edge, after inputs have settled
    always @(negedge clk) begin
        exp_t x;
        #4;
        if (q.size() > 0) begin
            x = q.pop_front();
            chk(x.tag, "stall", 32'(stall), 32'(x.stall));
            chk(x.tag, "flush", 32'(flush), 32'(x.flush));
            if (x.flush) chk(x.tag, "new_pc", new_pc, x.new_pc);
            chk(x.tag, "stall_cycles", stall_cycles, x.cyc);
            chk(x.tag, "wdog_timeout", 32'(wdog_timeout), 32'(x.wd));
        end
    end

    initial begin
        logic [31:0] causes [6];
        logic [31:0] exc;
        causes[0] = 32'h1; causes[1] = 32'h8; causes[2] = 32'ha;
        causes[3] = 32'hd; causes[4] = 32'hc; causes[5] = 32'he;
        rst = 1; stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        excepttype_i = '0; cp0_epc_i = '0;

        step(1, 0, 0, 0, 0, 0, 0, "rst0", 0);
        step(1, 0, 0, 0, 0, 0, 0, "rst1", 1);
        idle("reset_state");

        // EX and IF together: EX wins
        step(0, 1, 0, 1, 0, 0, 0, "ex_if", 1);
        idle("ex_if_cnt");

        // syscall with no memory busy
        step(0, 0, 0, 0, 0, 32'h8, 0, "sys_T", 1);
        idle("sys_T1");
        idle("sys_T2");

        // eret while memory busy for three cycles
        step(0, 0, 0, 0, 1, 32'he, 32'h8000_0100, "eret_T", 1);
        step(0, 0, 0, 0, 1, 0, 0, "eret_d1", 1);
        step(0, 0, 0, 0, 1, 0, 0, "eret_d2", 1);
        step(0, 0, 0, 0, 0, 32'h8, 0, "eret_D", 1);
        idle("eret_flush");
        idle("eret_run");

        // watchdog: LIMIT consecutive mem stalls, sticky until rst
        step(1, 0, 0, 0, 0, 0, 0, "wd_rst", 1);
        for (int k = 0; k < int'(LIMIT); k++) step(0, 0, 0, 0, 1, 0, 0, "wd_hold", 1);
        idle("wd_set");
        idle("wd_sticky");
        step(1, 0, 0, 0, 0, 0, 0, "wd_clr_rst", 1);
        idle("wd_clr");

        // rst during DRAIN: no flush, counters cleared
        step(0, 0, 0, 0, 1, 32'hc, 0, "drn_T", 1);
        step(0, 0, 0, 0, 1, 0, 0, "drn_1", 1);
        step(1, 0, 0, 0, 1, 0, 0, "drn_rst", 1);
        idle("drn_after");
        idle("drn_after2");

        // stall_cycles wrap
        @(posedge clk);
        #1;
        force dut.r_stall_cycles = 32'hFFFF_FFFF;
        #1;
        release dut.r_stall_cycles;
        m_cnt = 32'hFFFF_FFFF;
        step(0, 1, 0, 0, 0, 0, 0, "wrap_pre", 1);
        idle("wrap_post");

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            exc = ($urandom_range(7) == 0)
                ? (($urandom_range(3) == 0) ? ($urandom | 32'h1) : causes[$urandom_range(5)])
                : 32'd0;
            step(($urandom_range(63) == 0), ($urandom_range(2) == 0), ($urandom_range(2) == 0),
                 ($urandom_range(2) == 0), ($urandom_range(1) == 0), exc, $urandom, "rand", 1);
        end

        idle("tail");
        repeat (3) @(negedge clk);
        #6;
        n_vec++;
        if (q.size() != 0) begin
            n_mis++;
            $display("FAIL drain_queue: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
